// File: rtl/fetch_predictor.sv
// fetch_predictor: IF-stage branch predictor for the 5-stage core.
// It combines a direct-mapped BTB with a table of 2-bit saturating counters (PHT).
// Optional feature macro GSHARE_EN:
//   - defined: the PHT index is PC XOR global history, and the history shifts on every conditional branch.
//   - undefined: bimodal predictor indexed by PC bits only; the bhr output is tied to 0.
module fetch_predictor #(
  parameter int BTB_ENTRIES = 32,
  parameter int BHR_BITS    = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         current_pc,
  output logic [31:0]         pred_pc,
  output logic                pred_taken,
  input  logic                update_valid,
  input  logic [31:0]         update_pc,
  input  logic                update_is_branch,
  input  logic                update_taken,
  input  logic [31:0]         update_target,
  output logic [BHR_BITS-1:0] bhr
);

  localparam int IDX         = $clog2(BTB_ENTRIES);
  localparam int TAGW        = 30 - IDX;
  localparam int PHT_ENTRIES = 1 << BHR_BITS;

  // BTB storage: valid bits are reset, payload fields are not
  logic [BTB_ENTRIES-1:0] btbValid_q;
  logic [BTB_ENTRIES-1:0] btbJump_q;
  logic [TAGW-1:0]        btbTag_q    [BTB_ENTRIES];
  logic [31:0]            btbTarget_q [BTB_ENTRIES];

  // Pattern history table of 2-bit saturating counters
  logic [1:0]             pht_q [PHT_ENTRIES];

  // History value mixed into the PHT index (zero in the bimodal build)
  logic [BHR_BITS-1:0]    bhrMix;

  // Prediction-side signals
  logic [IDX-1:0]         predIdx;
  logic [TAGW-1:0]        predTag;
  logic [BHR_BITS-1:0]    phtRdIdx;
  logic                   predHit;

  // Update-side signals
  logic [IDX-1:0]         updIdx;
  logic [TAGW-1:0]        updTag;
  logic [BHR_BITS-1:0]    phtWrIdx;
  logic [1:0]             phtCnt_d;

  // The two low PC bits never take part in indexing or tagging
  logic [3:0]             unusedPcBits;
  assign unusedPcBits = {current_pc[1:0], update_pc[1:0]};

`ifdef GSHARE_EN
  logic [BHR_BITS-1:0] bhr_q;
  logic [BHR_BITS-1:0] bhr_d;

  // Shift the actual outcome of each conditional branch into the global history
  always_comb begin
    bhr_d = bhr_q;
    if (update_valid && update_is_branch) begin
      bhr_d = {bhr_q[BHR_BITS-2:0], update_taken};
    end
  end

  // Global history register, cleared on reset
  always_ff @(posedge clk) begin
    if (reset) begin
      bhr_q <= '0;
    end else begin
      bhr_q <= bhr_d;
    end
  end

  assign bhrMix = bhr_q;
  assign bhr    = bhr_q;
`else
  assign bhrMix = '0;
  assign bhr    = '0;
`endif

  // Zero-latency prediction from pre-edge state; reset forces the fall-through path
  always_comb begin
    predIdx    = current_pc[IDX+1:2];
    predTag    = current_pc[31:IDX+2];
    phtRdIdx   = current_pc[BHR_BITS+1:2] ^ bhrMix;
    predHit    = btbValid_q[predIdx] && (btbTag_q[predIdx] == predTag);
    pred_taken = !reset && predHit && (btbJump_q[predIdx] || pht_q[phtRdIdx][1]);
    pred_pc    = pred_taken ? btbTarget_q[predIdx] : current_pc + 32'd4;
  end

  // Training-side index/tag and saturating next value of the addressed counter
  always_comb begin
    updIdx   = update_pc[IDX+1:2];
    updTag   = update_pc[31:IDX+2];
    phtWrIdx = update_pc[BHR_BITS+1:2] ^ bhrMix;
    phtCnt_d = pht_q[phtWrIdx];
    if (update_taken) begin
      if (pht_q[phtWrIdx] != 2'b11) begin
        phtCnt_d = pht_q[phtWrIdx] + 2'd1;
      end
    end else begin
      if (pht_q[phtWrIdx] != 2'b00) begin
        phtCnt_d = pht_q[phtWrIdx] - 2'd1;
      end
    end
  end

  // Valid bits and counters: reset clears training, otherwise apply resolved outcomes
  always_ff @(posedge clk) begin
    if (reset) begin
      btbValid_q <= '0;
      for (int i = 0; i < PHT_ENTRIES; i++) begin
        pht_q[i] <= 2'b01;
      end
    end else if (update_valid) begin
      if (update_taken) begin
        btbValid_q[updIdx] <= 1'b1;
      end
      if (update_is_branch) begin
        pht_q[phtWrIdx] <= phtCnt_d;
      end
    end
  end

  // BTB payload is written only by taken updates; a taken update replaces any aliasing entry
  always_ff @(posedge clk) begin
    if (!reset && update_valid && update_taken) begin
      btbJump_q[updIdx]   <= !update_is_branch;
      btbTag_q[updIdx]    <= updTag;
      btbTarget_q[updIdx] <= update_target;
    end
  end

endmodule

// File: tb/tb_fetch_predictor.sv
// tb_fetch_predictor: scoreboard bench for fetch_predictor.
// A behavioural reference model produces the expected prediction for every driven cycle.
module tb_fetch_predictor;

  localparam int BTB_N = 32;
  localparam int BHR_N = 5;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [4:0]  hist;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] current_pc;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_is_branch;
  logic        update_taken;
  logic [31:0] update_target;
  logic [4:0]  bhr;

  int vectors = 0;
  int misses  = 0;

  exp_t sbQ[$];

  // Reference model state
  logic        mValid  [BTB_N];
  logic        mJump   [BTB_N];
  logic [24:0] mTag    [BTB_N];
  logic [31:0] mTarget [BTB_N];
  logic [1:0]  mPht    [1 << BHR_N];
  logic [4:0]  mBhr;

  fetch_predictor #(.BTB_ENTRIES(BTB_N), .BHR_BITS(BHR_N)) dut (
    .clk              (clk),
    .reset            (reset),
    .current_pc       (current_pc),
    .pred_pc          (pred_pc),
    .pred_taken       (pred_taken),
    .update_valid     (update_valid),
    .update_pc        (update_pc),
    .update_is_branch (update_is_branch),
    .update_taken     (update_taken),
    .update_target    (update_target),
    .bhr              (bhr)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      misses++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic int phtIndex(input logic [31:0] pc);
    logic [4:0] ix;
    ix = pc[6:2];
`ifdef GSHARE_EN
    ix = ix ^ mBhr;
`endif
    return int'(ix);
  endfunction

  function automatic exp_t modelPredict(input logic [31:0] pc, input logic rst);
    exp_t e;
    int   bi;
    logic hit;
    bi      = int'(pc[6:2]);
    hit     = mValid[bi] && (mTag[bi] == pc[31:7]);
    e.taken = !rst && hit && (mJump[bi] || mPht[phtIndex(pc)][1]);
    e.pc    = e.taken ? mTarget[bi] : pc + 32'd4;
    e.hist  = mBhr;
    return e;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < BTB_N; i++) mValid[i] = 1'b0;
    for (int i = 0; i < (1 << BHR_N); i++) mPht[i] = 2'b01;
    mBhr = '0;
  endtask

  task automatic modelUpdate(input logic [31:0] pc, input logic isBr, input logic tk, input logic [31:0] tgt);
    int bi;
    int pi;
    bi = int'(pc[6:2]);
    pi = phtIndex(pc);
    if (tk) begin
      mValid[bi]  = 1'b1;
      mJump[bi]   = !isBr;
      mTag[bi]    = pc[31:7];
      mTarget[bi] = tgt;
    end
    if (isBr) begin
      if (tk && mPht[pi] != 2'b11) mPht[pi] = mPht[pi] + 2'd1;
      if (!tk && mPht[pi] != 2'b00) mPht[pi] = mPht[pi] - 2'd1;
`ifdef GSHARE_EN
      mBhr = {mBhr[3:0], tk};
`endif
    end
  endtask

  // One cycle: drive at negedge, push expectation, sample, then advance the model past the edge
  task automatic applyStimulus(input logic [31:0] pc, input logic rst, input logic uv,
                               input logic [31:0] upc, input logic isBr, input logic tk,
                               input logic [31:0] tgt, input string tag);
    exp_t e;
    @(negedge clk);
    reset            = rst;
    current_pc       = pc;
    update_valid     = uv;
    update_pc        = upc;
    update_is_branch = isBr;
    update_taken     = tk;
    update_target    = tgt;
    sbQ.push_back(modelPredict(pc, rst));
    #1;
    if (sbQ.size() == 0) begin
      checkOutput({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      e = sbQ.pop_front();
      checkOutput({tag, ".pc"}, pred_pc, e.pc);
      checkOutput({tag, ".taken"}, {31'd0, pred_taken}, {31'd0, e.taken});
      checkOutput({tag, ".bhr"}, {27'd0, bhr}, {27'd0, e.hist});
    end
    @(posedge clk);
    #1;
    if (rst) modelReset();
    else if (uv) modelUpdate(upc, isBr, tk, tgt);
  endtask

  task automatic predictOnly(input logic [31:0] pc, input string tag);
    applyStimulus(pc, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, tag);
  endtask

  initial begin
    logic [31:0] pcSet [8];
    logic [31:0] rp;
    logic [31:0] up;
    logic        br;
    logic        tk;

    reset = 1'b1; current_pc = 32'h40; update_valid = 1'b0;
    update_pc = '0; update_is_branch = 1'b0; update_taken = 1'b0; update_target = '0;
    modelReset();
    for (int i = 0; i < BTB_N; i++) begin
      mJump[i] = 1'b0; mTag[i] = '0; mTarget[i] = '0;
    end
    repeat (2) @(posedge clk);

    // 1: reset behaviour and fall-through after reset
    applyStimulus(32'h40, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, "rst_hold");
    predictOnly(32'h40, "t1");
    checkOutput("t1.const", pred_pc, 32'h44);

    // 2: jal training; coincident prediction on the same entry sees the old state
    applyStimulus(32'h10, 1'b0, 1'b1, 32'h10, 1'b0, 1'b1, 32'h80, "t2.same");
    predictOnly(32'h10, "t2");
    checkOutput("t2.const", pred_pc, 32'h80);

    // 3: first taken conditional branch
    applyStimulus(32'h40, 1'b0, 1'b1, 32'h20, 1'b1, 1'b1, 32'h100, "t3.upd");
    predictOnly(32'h20, "t3");
`ifdef GSHARE_EN
    checkOutput("t3.const", pred_pc, 32'h24);
`else
    checkOutput("t3.const", pred_pc, 32'h100);
`endif

    // 4: counter saturation downwards, entry stays valid, one taken update
    for (int i = 0; i < 4; i++) begin
      applyStimulus(32'h20, 1'b0, 1'b1, 32'h20, 1'b1, 1'b0, 32'h100, "t4.nt");
    end
    predictOnly(32'h20, "t4.pred");
    applyStimulus(32'h40, 1'b0, 1'b1, 32'h20, 1'b1, 1'b1, 32'h100, "t4.tk");
    predictOnly(32'h20, "t4.after");
`ifndef GSHARE_EN
    checkOutput("t4.const", pred_pc, 32'h24);
`endif

    // 5: aliasing jumps share one BTB entry
    applyStimulus(32'h40, 1'b0, 1'b1, 32'h20, 1'b0, 1'b1, 32'h200, "t5.a");
    applyStimulus(32'h40, 1'b0, 1'b1, 32'hA0, 1'b0, 1'b1, 32'h300, "t5.b");
    predictOnly(32'h20, "t5.miss");
    checkOutput("t5.missc", pred_pc, 32'h24);
    predictOnly(32'hA0, "t5.hit");
    checkOutput("t5.hitc", pred_pc, 32'h300);

    // 6: reset wins over a coincident update and discards all training
    applyStimulus(32'hA0, 1'b1, 1'b1, 32'h40, 1'b0, 1'b1, 32'h500, "t6.rst");
    predictOnly(32'h10, "t6.a");
    predictOnly(32'hA0, "t6.b");
    checkOutput("t6.bc", pred_pc, 32'hA4);
    predictOnly(32'h40, "t6.c");
    checkOutput("t6.cc", pred_pc, 32'h44);

    // Wrap of the fall-through address
    predictOnly(32'hFFFF_FFFC, "wrap");
    checkOutput("wrap.const", pred_pc, 32'h0);

    // Randomised training over a small set of colliding and distinct PCs
    pcSet[0] = 32'h20;   pcSet[1] = 32'hA0;   pcSet[2] = 32'h124; pcSet[3] = 32'h8;
    pcSet[4] = 32'h1000; pcSet[5] = 32'h3C;   pcSet[6] = 32'hFFFF_FFFC; pcSet[7] = 32'h7C;
    for (int i = 0; i < 300; i++) begin
      rp = pcSet[$urandom_range(0, 7)];
      up = pcSet[$urandom_range(0, 7)];
      br = ($urandom_range(0, 3) != 0);
      tk = br ? $urandom_range(0, 1) == 1 : 1'b1;
      applyStimulus(rp, ($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0),
                    up, br, tk, {$urandom_range(0, 16'hFFFF), 16'h0} | up, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
